// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE array buses (input distribution and
// output gather): index-width helpers, flattened PE indexing and the
// tagged word format carried by the gather path.
package pe_array_pkg;

    // Default array geometry shared by the input-side and gather-side buses
    localparam int PA_DATA_WIDTH = 16;
    localparam int PA_NUM_ROW    = 4;
    localparam int PA_NUM_COL    = 4;

    // Width of a row index; a single-row array still gets a 1-bit field
    function automatic int rowIdxW(input int numRow);
        return (numRow > 1) ? $clog2(numRow) : 1;
    endfunction

    // Width of a column index; a single-column array still gets a 1-bit field
    function automatic int colIdxW(input int numCol);
        return (numCol > 1) ? $clog2(numCol) : 1;
    endfunction

    localparam int ROW_IDX_W = rowIdxW(PA_NUM_ROW);
    localparam int COL_IDX_W = colIdxW(PA_NUM_COL);

    // One gathered word tagged with the coordinates of the PE that produced it
    typedef struct packed {
        logic [ROW_IDX_W-1:0]     row_idx;
        logic [COL_IDX_W-1:0]     col_idx;
        logic [PA_DATA_WIDTH-1:0] data;
    } gather_entry_t;

    // Flattened PE number k = row*numCol + col
    function automatic int peIndex(input int row, input int col, input int numCol);
        return row * numCol + col;
    endfunction

    // Row of flattened PE k
    function automatic int peRow(input int k, input int numCol);
        return k / numCol;
    endfunction

    // Column of flattened PE k
    function automatic int peCol(input int k, input int numCol);
        return k % numCol;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// starting at ptr and wrapping modulo N. No grant at all while en is low.
module rr_arbiter #(
    parameter  int N     = 16,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic w_found;
    int   w_idx;

    // Walk the requesters from ptr onward and keep only the first hit
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int off = 0; off < N; off++) begin
            w_idx = (int'(ptr) + off) % N;
            if (en && !w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_idx    = IDX_W'(w_idx);
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/psum_gather_bus.sv
// Return-direction bus of the PE array: round-robin collects words from
// every PE into a first-word-fall-through FIFO, tagging each word with its
// source row/column, and drains the FIFO through a valid/ready stream.
module psum_gather_bus
    import pe_array_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_COL    = 4,
    parameter  int NUM_ROW    = 4,
    parameter  int FIFO_DEPTH = 8,
    localparam int NUM_PE     = NUM_ROW * NUM_COL,
    localparam int ROW_W      = rowIdxW(NUM_ROW),
    localparam int COL_W      = colIdxW(NUM_COL)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_PE-1:0]            pe_valid,
    input  logic [NUM_PE*DATA_WIDTH-1:0] pe_data,
    output logic [NUM_PE-1:0]            pe_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [ROW_W-1:0]             out_row,
    output logic [COL_W-1:0]             out_col,
    output logic                         busy,
    output logic [15:0]                  word_cnt
);

    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_PE  = IDX_W'(NUM_PE - 1);

    // Entry layout sized to this instance's geometry
    typedef struct packed {
        logic [ROW_W-1:0]      rowIdx;
        logic [COL_W-1:0]      colIdx;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic [IDX_W-1:0]  r_rrPtr;
    logic [15:0]       r_wordCnt;

    logic              w_arbEn;
    logic [NUM_PE-1:0] w_gnt;
    logic [IDX_W-1:0]  w_gntIdx;
    logic              w_push;
    logic              w_pop;
    entry_t            w_pushEntry;
    entry_t            w_head;

    // Grants are withheld while full (no bypass on a same-cycle pop),
    // during flush, and while reset is held so PEs keep their words
    assign w_arbEn = (r_count != FULL_CNT) && !flush && !rst;

    rr_arbiter #(.N(NUM_PE)) u_arb (
        .req     (pe_valid),
        .ptr     (r_rrPtr),
        .en      (w_arbEn),
        .gnt     (w_gnt),
        .gnt_idx (w_gntIdx)
    );

    assign pe_ready = w_gnt;
    assign w_push   = |w_gnt;
    assign w_pop    = (r_count != '0) && out_ready;

    // Tag the granted PE's word with its row and column
    always_comb begin
        w_pushEntry        = '0;
        w_pushEntry.rowIdx = ROW_W'(peRow(int'(w_gntIdx), NUM_COL));
        w_pushEntry.colIdx = COL_W'(peCol(int'(w_gntIdx), NUM_COL));
        w_pushEntry.data   = pe_data[int'(w_gntIdx)*DATA_WIDTH +: DATA_WIDTH];
    end

    // FIFO storage needs no reset; the pointers define which entries are live
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wrPtr] <= w_pushEntry;
        end
    end

    // Pointers, occupancy, arbitration pointer and word counter; flush wins over any transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_rrPtr   <= '0;
            r_wordCnt <= '0;
        end else if (flush) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_rrPtr   <= '0;
            r_wordCnt <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
                r_rrPtr <= (w_gntIdx == LAST_PE) ? '0 : w_gntIdx + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr   <= r_rdPtr + 1'b1;
                r_wordCnt <= r_wordCnt + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head of the FIFO is presented directly (first-word fall-through)
    always_comb begin
        w_head = r_mem[r_rdPtr];
    end

    assign out_valid = (r_count != '0);
    assign out_data  = w_head.data;
    assign out_row   = w_head.rowIdx;
    assign out_col   = w_head.colIdx;
    assign busy      = (r_count != '0) || (|pe_valid);
    assign word_cnt  = r_wordCnt;

endmodule

// File: tb/tb_psum_gather_bus.sv
// Self-checking bench for psum_gather_bus: a cycle model with a scoreboard
// queue tracks expected grants and FIFO contents, a vector table covers
// arbitration from a cleared pointer, and hand sequences cover rotation,
// full/no-bypass, flush and asynchronous reset.
module tb_psum_gather_bus;

   localparam int DW = 16;
   localparam int NC = 4;
   localparam int NR = 4;
   localparam int FD = 8;
   localparam int N  = NR * NC;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic [N-1:0]    pe_valid;
   logic [N*DW-1:0] pe_data;
   logic [N-1:0]    pe_ready;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic [1:0]      out_row;
   logic [1:0]      out_col;
   logic            busy;
   logic [15:0]     word_cnt;

   typedef struct packed {
      logic [1:0]    row;
      logic [1:0]    col;
      logic [DW-1:0] data;
   } exp_t;

   typedef struct {
      logic [N-1:0]  vld;
      logic [DW-1:0] data;
      int            idx;
      logic [1:0]    row;
      logic [1:0]    col;
   } vec_t;

   exp_t sbQ[$];
   int   mRr;
   int   mWc;
   int   errors = 0;
   int   checks = 0;
   vec_t tbl[6];

   psum_gather_bus #(
      .DATA_WIDTH (DW),
      .NUM_COL    (NC),
      .NUM_ROW    (NR),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .pe_valid  (pe_valid),
      .pe_data   (pe_data),
      .pe_ready  (pe_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .busy      (busy),
      .word_cnt  (word_cnt)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected grant: first valid PE from the model's round-robin pointer
   function automatic logic [N-1:0] modelGrant();
      logic [N-1:0] one;
      int k;
      one = 1;
      if (flush || rst || sbQ.size() >= FD) return '0;
      for (int off = 0; off < N; off++) begin
         k = (mRr + off) % N;
         if (pe_valid[k]) return one << k;
      end
      return '0;
   endfunction

   task automatic modelReset();
      sbQ.delete();
      mRr = 0;
      mWc = 0;
   endtask

   // One clock: compare against the model at the negedge, then advance the model at the posedge
   task automatic applyStimulus();
      logic [N-1:0] g;
      int           gi;
      bit           doPop;
      exp_t         e;
      @(negedge clk);
      g = modelGrant();
      checkOutput("pe_ready", pe_ready, g);
      checkOutput("out_valid", out_valid, sbQ.size() != 0);
      checkOutput("busy", busy, (sbQ.size() != 0) || (pe_valid != '0));
      checkOutput("word_cnt", word_cnt, mWc);
      if (sbQ.size() != 0 && out_valid) checkOutput("head", {out_row, out_col, out_data}, sbQ[0]);
      doPop = (sbQ.size() != 0) && out_ready;
      gi = -1;
      for (int k = 0; k < N; k++) if (g[k]) gi = k;
      @(posedge clk);
      if (flush) begin
         modelReset();
      end else begin
         if (doPop) begin
            void'(sbQ.pop_front());
            mWc = (mWc + 1) % 65536;
         end
         if (gi >= 0) begin
            e.row  = 2'(gi / NC);
            e.col  = 2'(gi % NC);
            e.data = pe_data[gi*DW +: DW];
            sbQ.push_back(e);
            mRr = (gi + 1) % N;
         end
      end
      #1;
   endtask

   initial begin
      logic [N-1:0] one;
      one = 1;

      tbl[0] = '{vld: 16'h0001, data: 16'h1111, idx: 0,  row: 2'd0, col: 2'd0};
      tbl[1] = '{vld: 16'h0020, data: 16'h00A5, idx: 5,  row: 2'd1, col: 2'd1};
      tbl[2] = '{vld: 16'h8000, data: 16'hF00F, idx: 15, row: 2'd3, col: 2'd3};
      tbl[3] = '{vld: 16'h0F00, data: 16'h0808, idx: 8,  row: 2'd2, col: 2'd0};
      tbl[4] = '{vld: 16'h1010, data: 16'h4444, idx: 4,  row: 2'd1, col: 2'd0};
      tbl[5] = '{vld: 16'hFFFE, data: 16'hBEEF, idx: 1,  row: 2'd0, col: 2'd1};

      rst       = 1'b1;
      flush     = 1'b0;
      pe_valid  = '0;
      pe_data   = '0;
      out_ready = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state, idle
      checkOutput("reset pe_ready", pe_ready, 0);
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset word_cnt", word_cnt, 0);
      applyStimulus();
      applyStimulus();

      // Vector table: arbitration from a cleared pointer, tagging and one pop
      for (int i = 0; i < 6; i++) begin
         flush     = 1'b1;
         pe_valid  = '0;
         out_ready = 1'b1;
         applyStimulus();
         flush    = 1'b0;
         pe_valid = tbl[i].vld;
         for (int k = 0; k < N; k++)
            pe_data[k*DW +: DW] = (k == tbl[i].idx) ? tbl[i].data : (16'hDEAD ^ 16'(k));
         #1;
         checkOutput("tbl grant", pe_ready, one << tbl[i].idx);
         applyStimulus();
         pe_valid = '0;
         #1;
         checkOutput("tbl out_valid", out_valid, 1);
         checkOutput("tbl out_data", out_data, tbl[i].data);
         checkOutput("tbl out_row", out_row, tbl[i].row);
         checkOutput("tbl out_col", out_col, tbl[i].col);
         applyStimulus();
         checkOutput("tbl word_cnt", word_cnt, 1);
      end

      // All PEs requesting: strict rotation, no gaps, pointer returns to 0
      flush = 1'b1;
      applyStimulus();
      flush     = 1'b0;
      pe_valid  = '1;
      out_ready = 1'b1;
      for (int k = 0; k < N; k++) pe_data[k*DW +: DW] = 16'(k);
      for (int c = 0; c < N; c++) begin
         applyStimulus();
         checkOutput("rot out_valid", out_valid, 1);
         checkOutput("rot out_data", out_data, c);
      end
      pe_valid = 16'h8001;
      #1;
      checkOutput("rot ptr back to 0", pe_ready, 16'h0001);
      applyStimulus();
      pe_valid = '0;
      repeat (3) applyStimulus();

      // Full FIFO, then a single pop does not let a push through the same cycle
      flush = 1'b1;
      applyStimulus();
      flush     = 1'b0;
      pe_valid  = '1;
      out_ready = 1'b0;
      repeat (FD) applyStimulus();
      checkOutput("full pe_ready", pe_ready, 0);
      checkOutput("full out_data", out_data, 0);
      out_ready = 1'b1;
      #1;
      checkOutput("no bypass pe_ready", pe_ready, 0);
      applyStimulus();
      out_ready = 1'b0;
      #1;
      checkOutput("after pop pe_ready", pe_ready, 16'h0100);
      applyStimulus();
      checkOutput("refull pe_ready", pe_ready, 0);
      pe_valid  = '0;
      out_ready = 1'b1;
      repeat (FD + 1) applyStimulus();

      // Flush with 5 entries held and PE 3 still requesting
      flush = 1'b1;
      applyStimulus();
      flush     = 1'b0;
      pe_valid  = 16'h0008;
      pe_data[3*DW +: DW] = 16'h3333;
      out_ready = 1'b1;
      repeat (3) applyStimulus();
      checkOutput("pre-flush word_cnt", word_cnt, 2);
      out_ready = 1'b0;
      for (int t = 0; t < 10 && sbQ.size() < 5; t++) applyStimulus();
      checkOutput("pre-flush fill", sbQ.size(), 5);
      flush = 1'b1;
      #1;
      checkOutput("flush pe_ready", pe_ready, 0);
      applyStimulus();
      flush    = 1'b0;
      pe_valid = '0;
      #1;
      checkOutput("post-flush out_valid", out_valid, 0);
      checkOutput("post-flush word_cnt", word_cnt, 0);
      applyStimulus();

      // Asynchronous reset between edges while words are held
      pe_valid = 16'h000F;
      for (int k = 0; k < N; k++) pe_data[k*DW +: DW] = 16'h7000 + 16'(k);
      out_ready = 1'b0;
      repeat (2) applyStimulus();
      checkOutput("pre-rst out_valid", out_valid, 1);
      pe_valid = 16'h0080;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("async rst out_valid", out_valid, 0);
      checkOutput("async rst pe_ready", pe_ready, 0);
      checkOutput("async rst word_cnt", word_cnt, 0);
      modelReset();
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checkOutput("post-rst grant PE7", pe_ready, 16'h0080);
      applyStimulus();
      pe_valid  = '0;
      out_ready = 1'b1;
      #1;
      checkOutput("post-rst out_data", out_data, 16'h7007);
      checkOutput("post-rst out_row", out_row, 1);
      checkOutput("post-rst out_col", out_col, 3);
      repeat (2) applyStimulus();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
